// File: rtl/io_input_fifo_pkg.sv
// Shared definitions for the byte input port: CPU handshake state encodings,
// the CPU word width and the value software reads at end-of-file.
package io_input_fifo_pkg;

   localparam int unsigned WORD_SIZE     = 16;
   localparam int unsigned IO_STATE_BITS = 2;

   typedef enum logic [IO_STATE_BITS-1:0] {
      IO_WAITREQ = 2'd0,
      IO_DOWORK  = 2'd1,
      IO_WAITACK = 2'd2
   } io_state_e;

   // Word software sees at EOF when the sentinel build option is enabled
   localparam logic [WORD_SIZE-1:0] IO_EOF_SENTINEL = '1;

endpackage

// File: rtl/io_input_fifo_fifo.sv
// Byte FIFO for the input port: power-of-two depth, naturally wrapping
// pointers, occupancy counter; push while full and pop while empty are ignored.
module io_fifo #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned BYTE_W = 8
) (
   input  logic                       clk,
   input  logic                       areset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [BYTE_W-1:0]          wdata,
   output logic [BYTE_W-1:0]          rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/io_input_fifo.sv
// CPU-facing byte input port: prefetch FIFO fed by a valid/ready source, 4-phase
// req/ack read with byte extension, sticky EOF. Option: IO_INPUT_EOF_SENTINEL_EN.
module io_input_fifo
   import io_input_fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = WORD_SIZE,
   parameter int unsigned BYTE_W   = 8,
   parameter int unsigned DEPTH    = 8,
   parameter bit          SIGN_EXT = 1'b0
) (
   input  logic                       clk,
   input  logic                       areset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BYTE_W-1:0]          in_data,
   input  logic                       in_eof,
   input  logic                       req,
   output logic                       ack,
   output logic [DATA_W-1:0]          data,
   output logic                       eof,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   io_state_e         state;
   io_state_e         nstate;
   logic [BYTE_W-1:0] head;
   logic              full;
   logic              empty;
   logic              eof_seen;
   logic              pop_c;
   logic              load_c;
   logic [DATA_W-1:0] load_val_c;
   logic [DATA_W-1:0] ext_c;

   io_fifo #(
      .DEPTH (DEPTH),
      .BYTE_W(BYTE_W)
   ) u_fifo (
      .clk     (clk),
      .areset_n(areset_n),
      .push    (in_valid && !full),
      .pop     (pop_c),
      .wdata   (in_data),
      .rdata   (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign in_ready = !full;
   assign eof      = eof_seen && empty;

   // Widen the FIFO head to a CPU word
   always_comb begin
      if (SIGN_EXT) ext_c = DATA_W'(signed'(head));
      else          ext_c = DATA_W'(head);
   end

   always_comb begin
      nstate     = state;
      pop_c      = 1'b0;
      load_c     = 1'b0;
      load_val_c = ext_c;
      case (state)
         IO_WAITREQ: begin
            if (req) nstate = IO_DOWORK;
         end
         IO_DOWORK: begin
            if (!empty) begin
               pop_c  = 1'b1;
               load_c = 1'b1;
               nstate = IO_WAITACK;
            end
`ifdef IO_INPUT_EOF_SENTINEL_EN
            else if (eof_seen) begin
               load_c     = 1'b1;
               load_val_c = '1;
               nstate     = IO_WAITACK;
            end
`endif
         end
         IO_WAITACK: begin
            if (!req) nstate = IO_WAITREQ;
         end
         default: nstate = IO_WAITREQ;
      endcase
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state    <= IO_WAITREQ;
         ack      <= 1'b0;
         data     <= '0;
         eof_seen <= 1'b0;
      end else begin
         state    <= nstate;
         ack      <= (nstate == IO_WAITACK);
         eof_seen <= eof_seen || in_eof;
         if (load_c) data <= load_val_c;
      end
   end

endmodule
